telemetry_framer: RTL and testbench

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

---
 rtl/telemetry_pkg.sv | 23 ++
 rtl/telemetry_framer_if.sv | 20 ++
 rtl/tick_gen.sv | 25 ++
 rtl/telemetry_framer.sv | 153 +++++++++++++++
 tb/tb_telemetry_framer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/telemetry_pkg.sv
// Shared constants and state encoding for the telemetry framer.
// Holds the sync bytes, the command codes and the frame FSM states.
package telemetry_pkg;

    localparam logic [7:0] SYNC0        = 8'hAA;
    localparam logic [7:0] SYNC1        = 8'h55;
    localparam logic [7:0] CMD_READ     = 8'h52;
    localparam logic [7:0] CMD_AUTO_ON  = 8'h41;
    localparam logic [7:0] CMD_AUTO_OFF = 8'h53;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SEND,
        WAIT_ACK,
        DONE
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/telemetry_framer_if.sv
// Serial command/transmit bundle between the framer and the UART side.
// master is the framer, slave is the serial receiver/transmitter.
interface telemetry_framer_if;
    logic [7:0] rx_data;
    logic       rx_new;
    logic [7:0] tx_data;
    logic       tx_new;
    logic       tx_busy;
    logic       tx_block;

    modport master (
        input  rx_data, rx_new, tx_busy, tx_block,
        output tx_data, tx_new
    );

    modport slave (
        output rx_data, rx_new, tx_busy, tx_block,
        input  tx_data, tx_new
    );
endinterface

// File: rtl/tick_gen.sv
// Free-running period counter; tick is high in the cycle the count wraps.
module tick_gen #(
    parameter int PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/telemetry_framer.sv
// Snapshots the channel words and streams them as a checksummed frame,
// triggered by a periodic tick (auto mode) or an 'R' command byte.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int WORD_BYTES    = 2,
    parameter int PERIOD        = 5000000,
    parameter bit AUTO_AT_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*WORD_BYTES*8-1:0] ch_data,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_new,
    output logic [7:0]                   tx_data,
    output logic                         tx_new,
    input  logic                         tx_busy,
    input  logic                         tx_block,
    output logic                         frame_active,
    output logic                         auto_en,
    output logic [7:0]                   seq,
    output logic [7:0]                   overrun
);
    localparam int PAY_BYTES = NUM_CH * WORD_BYTES;
    localparam int LAST_IDX  = PAY_BYTES + 4;
    localparam int IDX_W     = $clog2(LAST_IDX + 1);
    localparam int SLOTS     = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX_V = IDX_W'(LAST_IDX);

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next, pay_idx;
    logic [7:0]             csum_reg, csum_next;
    logic [7:0]             seq_reg, seq_next;
    logic [7:0]             overrun_reg, overrun_next;
    logic                   pending_reg, pending_next;
    logic                   auto_en_reg, ack_first_reg;
    logic [PAY_BYTES*8-1:0] snap_reg;
    logic [7:0]             pay_bytes [SLOTS];
    logic [7:0]             cur_byte;
    logic                   tick, cmd_read, trigger, strobe;

    tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cmd_read = rx_new && (rx_data == CMD_READ);
    assign trigger  = (tick && auto_en_reg) || cmd_read;
    assign seq_next = seq_reg + 8'd1;

    // Payload byte k: channel k/WORD_BYTES, most significant byte first.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pay
        if (gi < PAY_BYTES) begin : g_used
            assign pay_bytes[gi] = snap_reg[(gi / WORD_BYTES) * WORD_BYTES * 8
                                            + (WORD_BYTES - 1 - (gi % WORD_BYTES)) * 8 +: 8];
        end else begin : g_pad
            assign pay_bytes[gi] = 8'h00;
        end
    end

    assign pay_idx = idx_reg - IDX_W'(4);

    always_comb begin
        case (idx_reg)
            IDX_W'(0):  cur_byte = SYNC0;
            IDX_W'(1):  cur_byte = SYNC1;
            IDX_W'(2):  cur_byte = seq_next;
            IDX_W'(3):  cur_byte = 8'(NUM_CH);
            LAST_IDX_V: cur_byte = csum_reg;
            default:    cur_byte = pay_bytes[pay_idx];
        endcase
    end

    // rst gates the strobe so an aborted frame never emits a byte in the reset cycle.
    assign strobe = (state_reg == SEND) && !tx_busy && !tx_block && !rst;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        csum_next    = csum_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;

        case (state_reg)
            IDLE:     if (pending_reg || trigger) state_next = SNAP;
            SNAP: begin
                state_next = SEND;
                idx_next   = '0;
                csum_next  = '0;
            end
            SEND: if (strobe) begin
                state_next = WAIT_ACK;
                if (idx_reg >= IDX_W'(2) && idx_reg != LAST_IDX_V) begin
                    csum_next = csum_reg + cur_byte;
                end
            end
            WAIT_ACK: if (!ack_first_reg && !tx_busy) begin
                if (idx_reg == LAST_IDX_V) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = SEND;
                end
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        // In IDLE a trigger starts the frame directly; the queued one is consumed.
        if (state_reg == IDLE) begin
            pending_next = pending_reg && trigger;
        end else if (trigger) begin
            if (pending_reg) overrun_next = sat_inc8(overrun_reg);
            else             pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            csum_reg      <= '0;
            seq_reg       <= 8'hFF;
            overrun_reg   <= '0;
            pending_reg   <= 1'b0;
            auto_en_reg   <= AUTO_AT_RESET;
            ack_first_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            csum_reg      <= csum_next;
            overrun_reg   <= overrun_next;
            pending_reg   <= pending_next;
            ack_first_reg <= strobe;
            if (state_reg == DONE) seq_reg <= seq_next;
            if (rx_new && rx_data == CMD_AUTO_ON)       auto_en_reg <= 1'b1;
            else if (rx_new && rx_data == CMD_AUTO_OFF) auto_en_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == SNAP) snap_reg <= ch_data;
    end

    assign tx_new       = strobe;
    assign tx_data      = (state_reg == SEND) ? cur_byte : 8'h00;
    assign frame_active = (state_reg == SNAP) || (state_reg == SEND) || (state_reg == WAIT_ACK);
    assign auto_en      = auto_en_reg;
    assign seq          = seq_reg;
    assign overrun      = overrun_reg;
endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer with a small busy-driving transmitter model.
`timescale 1ns/1ps
module tb_telemetry_framer;
    import telemetry_pkg::*;

    localparam int NUM_CH        = 2;
    localparam int WORD_BYTES    = 2;
    localparam int PERIOD        = 64;
    localparam bit AUTO_AT_RESET = 1'b0;
    localparam int FB            = NUM_CH * WORD_BYTES + 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_CH*WORD_BYTES*8-1:0] ch_data;
    logic       frame_active, auto_en;
    logic [7:0] seq, overrun;

    telemetry_framer_if sif();

    telemetry_framer #(
        .NUM_CH(NUM_CH), .WORD_BYTES(WORD_BYTES),
        .PERIOD(PERIOD), .AUTO_AT_RESET(AUTO_AT_RESET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_data      (ch_data),
        .rx_data      (sif.rx_data),
        .rx_new       (sif.rx_new),
        .tx_data      (sif.tx_data),
        .tx_new       (sif.tx_new),
        .tx_busy      (sif.tx_busy),
        .tx_block     (sif.tx_block),
        .frame_active (frame_active),
        .auto_en      (auto_en),
        .seq          (seq),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] cap_data [$];
    int         cap_cyc  [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         trig_cyc = 0;

    // Transmitter: records each strobed byte and stays busy for two cycles after it.
    initial begin
        int busy_left;
        bit pend;
        busy_left   = 0;
        pend        = 1'b0;
        sif.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (sif.tx_new === 1'b1) begin
                cap_data.push_back(sif.tx_data);
                cap_cyc.push_back(cyc);
                pend = 1'b1;
            end
            @(posedge clk); #1;
            if (pend) begin
                sif.tx_busy = 1'b1;
                busy_left   = 2;
                pend        = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) sif.tx_busy = 1'b0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick_to(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst          = 1'b1;
        sif.rx_new   = 1'b0;
        sif.tx_block = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cap_data.delete();
        cap_cyc.delete();
    endtask

    task automatic send_cmd(input logic [7:0] b);
        sif.rx_data = b;
        sif.rx_new  = 1'b1;
        trig_cyc    = cyc;
        @(posedge clk); #1;
        sif.rx_new  = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (cap_data.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_val(tag, cap_data.size(), n);
    endtask

    task automatic check_frame(input int base, input logic [FB*8-1:0] want, input string tag);
        logic [7:0] got;
        for (int i = 0; i < FB; i++) begin
            got = (base + i < cap_data.size()) ? cap_data[base + i] : 8'hxx;
            check_val($sformatf("%s_b%0d", tag, i), got, want[(FB - 1 - i) * 8 +: 8]);
        end
    endtask

    initial begin
        int n0;
        ch_data      = {16'hABCD, 16'h1234};
        sif.rx_data  = 8'h00;
        sif.rx_new   = 1'b0;
        sif.tx_block = 1'b0;

        do_reset();
        check_val("rst_tx_new", sif.tx_new, 0);
        check_val("rst_tx_data", sif.tx_data, 8'h00);
        check_val("rst_active", frame_active, 0);
        check_val("rst_seq", seq, 8'hFF);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_auto", auto_en, AUTO_AT_RESET);

        send_cmd(8'h58);
        tick_to(10);
        check_val("ignore_cmd_auto", auto_en, 0);
        check_val("ignore_cmd_bytes", cap_data.size(), 0);

        // Basic frame and trigger latency
        send_cmd(CMD_READ);
        wait_bytes(FB, 200, "t1_len");
        check_val("t1_latency", cap_cyc[0] - trig_cyc, 2);
        check_frame(0, 72'hAA_55_00_02_12_34_AB_CD_C0, "t1");
        tick_to(8);
        check_val("t1_seq", seq, 8'h00);
        check_val("t1_active", frame_active, 0);

        // Three 'R' in one frame, ch_data changed mid-frame
        do_reset();
        send_cmd(CMD_READ);
        tick_to(10);
        ch_data = {16'h6666, 16'h5555};
        send_cmd(CMD_READ);
        tick_to(5);
        send_cmd(CMD_READ);
        wait_bytes(2 * FB, 400, "t2_len");
        tick_to(200);
        check_val("t2_total", cap_data.size(), 2 * FB);
        check_val("t2_overrun", overrun, 1);
        check_val("t2_seq", seq, 8'h01);
        check_frame(0, 72'hAA_55_00_02_12_34_AB_CD_C0, "t2a");
        check_frame(FB, 72'hAA_55_01_02_55_55_66_66_79, "t2b");

        // Flow-control hold mid-payload
        do_reset();
        ch_data = {16'hABCD, 16'h1234};
        send_cmd(CMD_READ);
        wait_bytes(6, 100, "t3_pre");
        sif.tx_block = 1'b1;
        n0 = cap_data.size();
        tick_to(1000);
        check_val("t3_hold_strobes", cap_data.size(), n0);
        check_val("t3_hold_active", frame_active, 1);
        sif.tx_block = 1'b0;
        wait_bytes(FB, 200, "t3_len");
        tick_to(20);
        check_val("t3_total", cap_data.size(), FB);
        check_frame(0, 72'hAA_55_00_02_12_34_AB_CD_C0, "t3");

        // Reset in the cycle the DUT would strobe payload byte 3
        do_reset();
        send_cmd(CMD_READ);
        wait_bytes(7, 100, "t4_pre");
        tick_to(3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("t4_active", frame_active, 0);
        rst = 1'b0;
        tick_to(50);
        check_val("t4_no_more", cap_data.size(), 7);
        check_val("t4_seq_kept", seq, 8'hFF);
        cap_data.delete();
        cap_cyc.delete();
        send_cmd(CMD_READ);
        wait_bytes(FB, 200, "t4_next_len");
        check_val("t4_next_seq", cap_data[2], 8'h00);

        // Auto mode: tick coinciding with 'R', period, seq wrap, stop
        do_reset();
        tick_to(1);
        send_cmd(CMD_AUTO_ON);
        check_val("t5_auto_on", auto_en, 1);
        tick_to(61);
        send_cmd(CMD_READ);
        wait_bytes(FB, 100, "t5_f1");
        check_val("t5_latency", cap_cyc[0] - trig_cyc, 2);
        check_val("t5_overrun", overrun, 0);
        wait_bytes(3 * FB, 300, "t5_f3");
        check_val("t5_period_a", cap_cyc[FB] - cap_cyc[0], 64);
        check_val("t5_period_b", cap_cyc[2 * FB] - cap_cyc[FB], 64);
        check_frame(0, 72'hAA_55_00_02_12_34_AB_CD_C0, "t5a");
        check_val("t5_f2_seq", cap_data[FB + 2], 8'h01);
        wait_bytes(257 * FB, 257 * 64 + 500, "t5_f257");
        send_cmd(CMD_AUTO_OFF);
        check_val("t5_auto_off", auto_en, 0);
        tick_to(20);
        check_val("t5_seq_wrap", seq, 8'h00);
        check_val("t5_f256_seq", cap_data[255 * FB + 2], 8'hFF);
        check_val("t5_f257_seq", cap_data[256 * FB + 2], 8'h00);
        check_val("t5_f257_sync", cap_data[256 * FB], 8'hAA);
        n0 = cap_data.size();
        tick_to(300);
        check_val("t5_stopped", cap_data.size(), n0);
        check_val("t5_idle", frame_active, 0);
        check_val("t5_overrun_end", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
